// File: rtl/spi_pkg.sv
// spi_pkg: constants and types shared by the SPI master and its shift register.
//   OP_*    : 2-bit opcode found in cmd_word[WORD_W-1 -: 2]
//   state_t : master FSM state encoding
//   CNT_W   : width of the per-state bit counter
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CMD     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DESEL   = 3'd6
    } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load shift register, MSB-first serial out, serial-in
// at the LSB. One register serves both directions: the command word leaves
// from the top while captured read bits enter at the bottom.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : load load_val_i (has priority over shift_i)
//   shift_i      : shift left one bit, ser_i enters at bit 0
//   ser_o        : current MSB
//   cap_o        : low CAP_W bits (most recent serial-in bits)
module spi_shift_reg #(
    parameter int W     = 10,
    parameter int CAP_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [CAP_W-1:0] cap_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        sr_q <= '0;
        else if (load_i)  sr_q <= load_val_i;
        else if (shift_i) sr_q <= {sr_q[W-2:0], ser_i};
    end

    assign ser_o = sr_q[W-1];
    assign cap_o = sr_q[CAP_W-1:0];

endmodule

// File: rtl/spi_master.sv
// spi_master: single-clock SPI master. Sends a WORD_W-bit command MSB first;
// for RD_DATA opcodes it waits RD_LAT cycles and then captures DATA_W bits
// from MISO. The slave shifts on CLK itself.
//   CLK, rst             : clock, async active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_word             : frame to send
//   SS_n, MOSI, MISO     : SPI wires
//   rd_data/rd_valid     : captured read byte and its one-cycle strobe
//   done                 : one-cycle strobe at the end of every frame
// DATA_W must not exceed WORD_W: capture reuses the command shift register.
module spi_master
    import spi_pkg::*;
#(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_word,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done
);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_W - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               ss_n_q, mosi_q, done_q, rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;

    logic               sr_load, sr_shift, sr_in, sr_msb;
    logic [DATA_W-2:0]  sr_cap;

    // The shift register is advanced one cycle ahead of the MOSI flop, so its
    // MSB is always the bit MOSI must show in the following cycle.
    assign sr_load  = (state_q == ST_IDLE) && cmd_valid;
    assign sr_shift = (state_q == ST_CMD) || (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);
    assign sr_in    = (state_q == ST_CAPTURE) && MISO;

    spi_shift_reg #(
        .W    (WORD_W),
        .CAP_W(DATA_W - 1)
    ) u_sr (
        .clk_i     (CLK),
        .rst_i     (rst),
        .load_i    (sr_load),
        .load_val_i(cmd_word),
        .shift_i   (sr_shift),
        .ser_i     (sr_in),
        .ser_o     (sr_msb),
        .cap_o     (sr_cap)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_WR_ADDR;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (cmd_valid) begin
                        state_q <= ST_SELECT;
                        op_q    <= cmd_word[WORD_W-1 -: 2];
                        ss_n_q  <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    state_q <= ST_CMD;
                    cnt_q   <= '0;
                    mosi_q  <= sr_msb;
                end
                ST_CMD: begin
                    state_q <= ST_SHIFT;
                    cnt_q   <= '0;
                    mosi_q  <= sr_msb;
                end
                ST_SHIFT: begin
                    if (cnt_q == SHIFT_LAST) begin
                        cnt_q  <= '0;
                        mosi_q <= 1'b0;
                        if (op_q == OP_RD_DATA) begin
                            state_q <= (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
                        end else begin
                            state_q <= ST_DESEL;
                            ss_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        mosi_q <= sr_msb;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= ST_CAPTURE;
                        cnt_q   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_q == CAP_LAST) begin
                        state_q    <= ST_DESEL;
                        cnt_q      <= '0;
                        ss_n_q     <= 1'b1;
                        done_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        // Final MISO bit is taken straight from the pin, the
                        // earlier ones from the shift register.
                        rd_data_q  <= {sr_cap, MISO};
                    end
                end
                ST_DESEL: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a pure state decode, so it rises as soon as reset releases.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: two masters (RD_LAT=2 and RD_LAT=0) checked cycle by cycle
// against frame timing derived from the frame length arithmetic, plus a
// wire-level slave with an 8-bit RAM for loopback.
module tb_spi_master;

    logic              CLK = 1'b0;
    logic              rst;
    logic [1:0]        cv;
    logic [1:0][9:0]   cw;
    logic [1:0]        miso;
    wire  [1:0]        rdy, ss, mosi, rdv, dn;
    wire  [1:0][7:0]   rdd;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_rd [2];
    logic [7:0] sl_ram [256];
    logic [7:0] sl_addr;
    logic [7:0] ref_ram [256];
    logic [7:0] ref_addr;

    always #5 CLK = ~CLK;

    spi_master #(.WORD_W(10), .DATA_W(8), .RD_LAT(2)) dut2 (
        .CLK(CLK), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy[0]), .cmd_word(cw[0]),
        .SS_n(ss[0]), .MOSI(mosi[0]), .MISO(miso[0]), .rd_data(rdd[0]),
        .rd_valid(rdv[0]), .done(dn[0]));

    spi_master #(.WORD_W(10), .DATA_W(8), .RD_LAT(0)) dut0 (
        .CLK(CLK), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy[1]), .cmd_word(cw[1]),
        .SS_n(ss[1]), .MOSI(mosi[1]), .MISO(miso[1]), .rd_data(rdd[1]),
        .rd_valid(rdv[1]), .done(dn[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on unit u starting from a negedge in IDLE; returns at the
    // negedge of the IDLE cycle following DESEL.
    task automatic run_frame(input int u, input logic [9:0] w, input logic [7:0] byte_in,
                             input bit use_slave, input bit keep);
        int lat, len, cs;
        bit is_rd;
        logic [9:0] obs_w;
        logic [7:0] sbyte;
        logic exp_mosi;
        lat   = (u == 0) ? 2 : 0;
        is_rd = (w[9:8] == 2'b11);
        len   = 13 + (is_rd ? lat + 8 : 0);
        cs    = 13 + lat;
        obs_w = '0;
        sbyte = byte_in;
        cv[u] = 1'b1;
        cw[u] = w;
        chk($sformatf("u%0d ready_idle", u), 32'(rdy[u]), 1);
        @(posedge CLK);
        for (int k = 1; k <= len; k++) begin
            @(negedge CLK);
            if (!keep) cv[u] = 1'b0;
            if (k >= 3 && k <= 12) obs_w[12-k] = mosi[u];
            if (k == 12 && use_slave) begin
                case (obs_w[9:8])
                    2'b00, 2'b10: sl_addr = obs_w[7:0];
                    2'b01:        sl_ram[sl_addr] = obs_w[7:0];
                    default:      sbyte = sl_ram[sl_addr];
                endcase
            end
            if (is_rd && k >= cs && k < cs + 8) miso[u] = sbyte[7-(k-cs)];
            else                                miso[u] = 1'($urandom_range(0, 1));
            if (k == 2)                exp_mosi = w[9];
            else if (k >= 3 && k <= 12) exp_mosi = w[12-k];
            else                        exp_mosi = 1'b0;
            chk($sformatf("u%0d w%0h ss k=%0d", u, w, k),   32'(ss[u]),   (k < len) ? 0 : 1);
            chk($sformatf("u%0d w%0h mosi k=%0d", u, w, k), 32'(mosi[u]), 32'(exp_mosi));
            chk($sformatf("u%0d w%0h done k=%0d", u, w, k), 32'(dn[u]),   (k == len) ? 1 : 0);
            chk($sformatf("u%0d w%0h rdv k=%0d", u, w, k),  32'(rdv[u]),  (k == len && is_rd) ? 1 : 0);
            chk($sformatf("u%0d w%0h rdy k=%0d", u, w, k),  32'(rdy[u]),  0);
        end
        // Reference model of the slave RAM, driven by intent rather than the wire.
        if (use_slave) begin
            case (w[9:8])
                2'b00, 2'b10: ref_addr = w[7:0];
                2'b01:        ref_ram[ref_addr] = w[7:0];
                default:      exp_rd[u] = ref_ram[ref_addr];
            endcase
        end else if (is_rd) begin
            exp_rd[u] = byte_in;
        end
        chk($sformatf("u%0d w%0h rd_data", u, w), 32'(rdd[u]), 32'(exp_rd[u]));
        @(negedge CLK);
        chk($sformatf("u%0d idle ss", u),   32'(ss[u]),  1);
        chk($sformatf("u%0d idle done", u), 32'(dn[u]),  0);
        chk($sformatf("u%0d idle rdv", u),  32'(rdv[u]), 0);
        chk($sformatf("u%0d idle rdy", u),  32'(rdy[u]), 1);
        chk($sformatf("u%0d idle rd_data", u), 32'(rdd[u]), 32'(exp_rd[u]));
    endtask

    initial begin
        rst  = 1'b1;
        cv   = '0;
        cw   = '0;
        miso = '0;
        sl_addr  = '0;
        ref_addr = '0;
        for (int i = 0; i < 256; i++) begin
            sl_ram[i]  = '0;
            ref_ram[i] = '0;
        end
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d rst ss", u),   32'(ss[u]),   1);
            chk($sformatf("u%0d rst mosi", u), 32'(mosi[u]), 0);
            chk($sformatf("u%0d rst rdd", u),  32'(rdd[u]),  0);
            chk($sformatf("u%0d rst rdv", u),  32'(rdv[u]),  0);
            chk($sformatf("u%0d rst done", u), 32'(dn[u]),   0);
            chk($sformatf("u%0d rst rdy", u),  32'(rdy[u]),  0);
        end
        rst = 1'b0;
        #1;
        chk("rdy after rst u0", 32'(rdy[0]), 1);
        chk("rdy after rst u1", 32'(rdy[1]), 1);
        @(negedge CLK);

        // Directed frames
        run_frame(0, 10'h0A5, 8'h00, 1'b0, 1'b0);
        run_frame(0, 10'h3FF, 8'hC3, 1'b0, 1'b0);
        run_frame(1, 10'h300, 8'h81, 1'b0, 1'b0);
        run_frame(1, 10'h2C4, 8'h00, 1'b0, 1'b0);

        // Back-to-back with cmd_valid held high
        run_frame(0, 10'h1AB, 8'h00, 1'b0, 1'b1);
        run_frame(0, 10'h3F0, 8'h96, 1'b0, 1'b1);
        run_frame(0, 10'h055, 8'h00, 1'b0, 1'b1);
        cv[0] = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("b2b idle ss", 32'(ss[0]), 1);
            chk("b2b idle rdy", 32'(rdy[0]), 1);
        end

        // Reset mid-SHIFT
        cv[0] = 1'b1;
        cw[0] = 10'h3A7;
        @(posedge CLK);
        @(negedge CLK);
        cv[0] = 1'b0;
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #1 rst = 1'b1;
        #1;
        chk("abort ss", 32'(ss[0]), 1);
        chk("abort mosi", 32'(mosi[0]), 0);
        chk("abort rdy", 32'(rdy[0]), 0);
        chk("abort rdd", 32'(rdd[0]), 0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (3) begin
            @(negedge CLK);
            chk("abort done", 32'(dn[0]), 0);
            chk("abort rdv", 32'(rdv[0]), 0);
            chk("abort ss hold", 32'(ss[0]), 1);
        end
        rst = 1'b0;
        #1 chk("abort rdy release", 32'(rdy[0]), 1);
        @(negedge CLK);
        run_frame(0, 10'h0C3, 8'h00, 1'b0, 1'b0);
        run_frame(0, 10'h300, 8'h3C, 1'b0, 1'b0);

        // Loopback through the wire-level slave RAM
        run_frame(0, 10'h012, 8'h00, 1'b1, 1'b0);
        run_frame(0, 10'h15A, 8'h00, 1'b1, 1'b0);
        run_frame(0, 10'h212, 8'h00, 1'b1, 1'b0);
        run_frame(0, 10'h300, 8'h00, 1'b1, 1'b0);
        chk("loopback rd 5A", 32'(rdd[0]), 32'h5A);

        // Randomized frames on both units
        for (int n = 0; n < 40; n++) begin
            int u;
            logic [9:0] w;
            logic [7:0] b;
            bit sl;
            u  = int'($urandom_range(0, 1));
            w  = 10'($urandom);
            b  = 8'($urandom);
            sl = 1'($urandom_range(0, 1));
            run_frame(u, w, b, sl, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
